// File: rtl/frame_deser.sv
// Serial frame deserializer: start bit, W data bits LSB-first, stop bit.
// Received words go into a D-deep first-word-fall-through FIFO.
module frame_deser #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sin,
  output logic [W-1:0]          out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  frame_err,
  output logic                  ovf,
  output logic [$clog2(D):0]    level
);

  localparam int CW = $clog2(W);
  localparam int AW = $clog2(D);

  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  bit_cnt;
  logic [W-1:0]   shreg;
  logic [W-1:0]   mem [D];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic           push, pop, accept, full;

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (!sin) state_nxt = DATA;
      DATA: if (bit_cnt == CW'(W - 1)) state_nxt = STOP;
      STOP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Data bits shift in from the top, so the first bit lands in bit 0 after W shifts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      unique case (state)
        IDLE: bit_cnt <= '0;
        DATA: begin
          shreg   <= {sin, shreg[W-1:1]};
          bit_cnt <= bit_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign push      = (state == STOP) && sin;
  assign full      = (level == (AW + 1)'(D));
  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready;
  // When full, a same-cycle pop frees the slot the new word is written into.
  assign accept    = push && (!full || pop);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // NOTE: storage is not reset; out_data is masked while empty, so stale contents never show.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      frame_err <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
      unique case ({accept, pop})
        2'b10:   level <= level + (AW + 1)'(1);
        2'b01:   level <= level - (AW + 1)'(1);
        default: level <= level;
      endcase
      // A bad stop bit needs sin low and a push needs it high, so these never coincide.
      frame_err <= (state == STOP) && !sin;
      ovf       <= push && full && !pop;
    end
  end

endmodule

// File: tb/tb_frame_deser.sv
// Randomized bench for frame_deser: a queue-based reference buffer is updated
// per clock and a negedge monitor compares every DUT output against it.
module tb_frame_deser;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int W2 = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          sin;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_valid, frame_err, ovf;
  logic [2:0]    level;

  logic          sin12, out_ready12;
  logic [W2-1:0] out_data12;
  logic          out_valid12, frame_err12, ovf12;
  logic [2:0]    level12;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  frame_deser #(.W(W), .D(D)) dut (
    .clk(clk), .rst(rst), .sin(sin), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .frame_err(frame_err), .ovf(ovf), .level(level)
  );

  frame_deser #(.W(W2)) dut12 (
    .clk(clk), .rst(rst), .sin(sin12), .out_data(out_data12), .out_valid(out_valid12),
    .out_ready(out_ready12), .frame_err(frame_err12), .ovf(ovf12), .level(level12)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: buffer contents as a queue plus expected pulses.
  logic [W-1:0] model_q[$];
  logic         exp_ovf, exp_ferr;
  logic         stop_flag = 1'b0;
  logic         stop_good;
  logic [W-1:0] stop_word;
  int           ready_mode = 0;   // 0/1: fixed out_ready, 2: random per cycle
  logic         ready_on_stop = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_q.delete();
      exp_ovf  = 1'b0;
      exp_ferr = 1'b0;
    end else begin
      exp_ovf  = 1'b0;
      exp_ferr = 1'b0;
      if (out_ready && model_q.size() != 0) void'(model_q.pop_front());
      if (stop_flag) begin
        if (!stop_good)               exp_ferr = 1'b1;
        else if (model_q.size() < D)  model_q.push_back(stop_word);
        else                          exp_ovf = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("mon_level", level, model_q.size());
      check("mon_valid", out_valid, model_q.size() != 0);
      check("mon_data", out_data, model_q.size() != 0 ? model_q[0] : '0);
      check("mon_ovf", ovf, exp_ovf);
      check("mon_frame_err", frame_err, exp_ferr);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (ready_mode == 2) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_frame(input logic [W-1:0] w, input logic good);
    sin = 1'b0;
    step();
    for (int i = 0; i < W; i++) begin
      sin = w[i];
      step();
    end
    sin       = good;
    stop_word = w;
    stop_good = good;
    stop_flag = 1'b1;
    if (ready_on_stop) out_ready = 1'b1;
    step();
    stop_flag = 1'b0;
    sin       = 1'b1;
    if (ready_on_stop) out_ready = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (D + 1) step();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [W2-1:0] words12 [2];
    rst = 1'b1; sin = 1'b1; out_ready = 1'b0; sin12 = 1'b1; out_ready12 = 1'b0;
    #2;
    check("reset_valid", out_valid, 1'b0);
    check("reset_data", out_data, 8'h00);
    check("reset_level", level, 3'd0);
    check("reset_ferr_ovf", {frame_err, ovf}, 2'b00);
    @(posedge clk); #1 rst = 1'b0;
    step();

    // Single good frame, no consumer.
    send_frame(8'hA5, 1'b1);
    check("a5_valid", out_valid, 1'b1);
    check("a5_data", out_data, 8'hA5);
    check("a5_level", level, 3'd1);
    drain();

    // Bad stop bit.
    send_frame(8'h3C, 1'b0);
    check("ferr_pulse", frame_err, 1'b1);
    check("ferr_level", level, 3'd0);
    check("ferr_valid", out_valid, 1'b0);
    step();
    check("ferr_one_cycle", frame_err, 1'b0);

    // Overflow on the fifth frame, then ordered drain.
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    check("ovf_pulse", ovf, 1'b1);
    check("ovf_level", level, 3'd4);
    step();
    check("ovf_one_cycle", ovf, 1'b0);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("ovf_pop_order", out_data, 32'(i));
      step();
    end
    out_ready = 1'b0;
    check("ovf_drained", level, 3'd0);

    // Full buffer with a pop on the cycle the fifth push lands.
    for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b1);
    ready_on_stop = 1'b1;
    send_frame(8'h15, 1'b1);
    ready_on_stop = 1'b0;
    check("fullpop_no_ovf", ovf, 1'b0);
    check("fullpop_level", level, 3'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("fullpop_order", out_data, 32'(8'h12 + 8'(i)));
      step();
    end
    out_ready = 1'b0;

    // Reset in the middle of a frame, with a word already buffered.
    send_frame(8'h77, 1'b1);
    sin = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      sin = 1'($urandom_range(0, 1));
      step();
    end
    rst = 1'b1;
    #1;
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_data", out_data, 8'h00);
    check("midrst_level", level, 3'd0);
    check("midrst_pulses", {frame_err, ovf}, 2'b00);
    sin = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    step();
    step();
    send_frame(8'h5A, 1'b1);
    check("after_rst_data", out_data, 8'h5A);
    check("after_rst_level", level, 3'd1);
    drain();

    // Randomized traffic: random words, gaps, bad stops and consumer stalls.
    ready_mode = 2;
    for (int n = 0; n < 150; n++) begin
      int gap = $urandom_range(0, 2);
      repeat (gap) step();
      send_frame(8'($urandom), $urandom_range(0, 7) != 0);
    end
    ready_mode = 0;
    drain();
    check("random_drained", level, 3'd0);

    // Wider payload: two back-to-back frames with no idle gap.
    words12[0] = 12'hABC;
    words12[1] = 12'h123;
    for (int f = 0; f < 2; f++) begin
      sin12 = 1'b0;
      step();
      for (int i = 0; i < W2; i++) begin
        sin12 = words12[f][i];
        step();
      end
      sin12 = 1'b1;
      step();
    end
    check("w12_level", level12, 3'd2);
    check("w12_first", out_data12, 12'hABC);
    out_ready12 = 1'b1;
    step();
    check("w12_second", out_data12, 12'h123);
    check("w12_level_after_pop", level12, 3'd1);
    step();
    out_ready12 = 1'b0;
    check("w12_empty", level12, 3'd0);
    check("w12_no_err", {frame_err12, ovf12}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/frame_deser.md
FRAME_DESER -- requirements
Module: frame_deser

Interface
REQ-001 Parameter W, default 8: payload width in bits; legal range W >= 2.
REQ-002 Parameter D, default 4: output buffer depth in words; power of two, D >= 2.
REQ-003 clk  input  1  rising-edge clock; the only clock.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 sin  input  1  serial line, idle high, one bit per clk (no oversampling).
REQ-006 out_data  output  W  head word of output buffer.
REQ-007 out_valid  output  1  buffer non-empty; out_data is valid.
REQ-008 out_ready  input  1  consumer accepts out_data this cycle.
REQ-009 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 ovf  output  1  one-cycle pulse: completed word dropped, buffer full.
REQ-011 level  output  clog2(D)+1  current buffer occupancy, 0..D.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, DATA, STOP.
REQ-013 IDLE: sin==0 sampled -> DATA, bit counter cleared; sin==1 -> stay IDLE.
REQ-014 DATA: each cycle, the sampled sin SHALL be stored LSB-first (k-th data bit -> bit k); after the W-th bit -> STOP.
REQ-015 STOP, sin==1: assembled word SHALL be pushed to the buffer; -> IDLE.
REQ-016 STOP, sin==0: word discarded, frame_err=1 for exactly that following cycle; -> IDLE (next low bit is treated as a new start bit).
REQ-017 Latency: a pushed word SHALL appear on out_valid/out_data and in level on the cycle after its stop bit is sampled.
REQ-018 Back-to-back frames (start bit on the cycle right after the stop bit) SHALL be received without loss.
REQ-019 Buffer: FIFO, first-word-fall-through; out_data = oldest stored word whenever out_valid=1.
REQ-020 Pop occurs on any cycle where out_valid && out_ready; out_ready is ignored when out_valid=0.
REQ-021 out_data SHALL be held stable while out_valid=1 and out_ready=0.
REQ-022 Push when level<D: accepted; level +1 (unless a simultaneous pop).
REQ-023 Push when level==D with a simultaneous pop: accepted; level stays D; no ovf.
REQ-024 Push when level==D without a pop: word dropped, ovf=1 for one cycle, buffer contents unchanged.
REQ-025 Simultaneous push and pop at 0<level<D: level unchanged, order preserved.
REQ-026 Read/write pointers SHALL wrap modulo D; level SHALL never exceed D nor underflow below 0.
REQ-027 frame_err and ovf are registered outputs and are never asserted in the same cycle (mutually exclusive by construction).

Reset
REQ-028 rst=1 SHALL immediately force: state IDLE, bit counter 0, buffer empty, pointers 0, out_valid=0, out_data=0, level=0, frame_err=0, ovf=0.
REQ-029 Reset asserted mid-frame SHALL discard the partial word; no push, frame_err, or ovf results from it.
REQ-030 After rst deasserts, the first sampled sin==0 in IDLE SHALL be treated as a start bit.

Verification (W=8, D=4 unless stated)
REQ-031 sin: 0, bits of 0xA5 LSB-first, 1; out_ready=0 -> next cycle: out_valid=1, out_data=0xA5, level=1.
REQ-032 Frame 0x3C with stop bit 0 -> frame_err=1 for one cycle; level=0; out_valid=0.
REQ-033 out_ready=0; frames 0x01..0x05 -> level=4; ovf pulse after the 5th frame; then out_ready=1 pops 0x01,0x02,0x03,0x04.
REQ-034 Buffer full; out_ready=1 during the cycle the 5th push lands -> no ovf; level stays 4; pop order preserved.
REQ-035 rst pulse after 4 DATA bits -> all outputs 0 asynchronously; a following frame 0x5A is received correctly.
REQ-036 Override only W=12 (D left at default): two back-to-back frames 0xABC, 0x123 with no idle gap -> both delivered in order; level=2.
